// File: rtl/juiz_jogada_param_pkg.sv
// Shared types for the note/tempo judge: FSM state encoding, play-mode codes
// and the rule that turns the note/tempo comparisons into a wrong-move flag.
package juiz_jogada_param_pkg;

  typedef enum logic [2:0] {
    OCIOSO = 3'd0,
    ESPERA = 3'd1,
    MEDE   = 3'd2,
    AVALIA = 3'd3,
    FIM    = 3'd4
  } estado_t;

  localparam logic [1:0] MODO_NOTA_TEMPO = 2'b00;
  localparam logic [1:0] MODO_NOTA       = 2'b01;
  localparam logic [1:0] MODO_TEMPO      = 2'b10;
  localparam logic [1:0] MODO_AMBOS      = 2'b11;

  // Modo 11 behaves like 00: both the note and the tempo must be right.
  function automatic logic calcula_errou(input logic [1:0] modo,
                                         input logic       nota_ok,
                                         input logic       tempo_ok);
    case (modo)
      MODO_NOTA:  return !nota_ok;
      MODO_TEMPO: return !tempo_ok;
      default:    return !(nota_ok && tempo_ok);
    endcase
  endfunction

endpackage

// File: rtl/contador_m.sv
// Generic up-counter with synchronous clear and saturation at MAX; the clear
// wins over a simultaneous count request.
module contador_m #(
  parameter int W   = 8,
  parameter int MAX = 255
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  output logic [W-1:0] valor
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valor <= '0;
    end else if (zera) begin
      valor <= '0;
    end else if (conta && (valor != W'(MAX))) begin
      valor <= valor + W'(1);
    end
  end

endmodule

// File: rtl/onehot_encoder_param.sv
// Turns the debounced button bank into a note index, flagging whether exactly
// one button is pressed or several are pressed at once.
module onehot_encoder_param #(
  parameter int N = 13,
  parameter int W = 4
) (
  input  logic [N-1:0] entrada,
  output logic [W-1:0] indice,
  output logic         valido,
  output logic         multiplo
);

  logic [N-1:0] resto;

  // Clearing the lowest set bit leaves something only when two or more are high.
  assign resto    = entrada & (entrada - N'(1));
  assign multiplo = |resto;
  assign valido   = (|entrada) && !(|resto);

  always_comb begin
    indice = '0;
    for (int i = 0; i < N; i++) begin
      if (entrada[i]) begin
        indice = W'(i);
      end
    end
  end

endmodule

// File: rtl/juiz_jogada_param.sv
// Judges one player move: captures the pressed note, measures hold time in
// metronome ticks, compares both with the expected values and counts errors.
module juiz_jogada_param
  import juiz_jogada_param_pkg::*;
#(
  parameter int N_NOTAS  = 13,
  parameter int TEMPO_W  = 8,
  parameter int TOL      = 1,
  parameter int ERRO_MAX = 3,
  parameter int TIMEOUT  = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          iniciar,
  input  logic                          tick,
  input  logic [N_NOTAS-1:0]            botoes,
  input  logic [$clog2(N_NOTAS)-1:0]    nota_esperada,
  input  logic [TEMPO_W-1:0]            tempo_esperado,
  input  logic [1:0]                    modo,
  input  logic                          zera_erros,
  output logic                          pronto,
  output logic                          nota_correta,
  output logic                          tempo_correto,
  output logic                          tempo_baixo,
  output logic                          errou,
  output logic                          timeout,
  output logic [$clog2(N_NOTAS)-1:0]    nota_tocada,
  output logic [TEMPO_W-1:0]            duracao,
  output logic [$clog2(ERRO_MAX+1)-1:0] erros,
  output logic                          limite_erros
);

  localparam int NOTA_W   = $clog2(N_NOTAS);
  localparam int ERRO_W   = $clog2(ERRO_MAX + 1);
  localparam int ESPERA_W = $clog2(TIMEOUT + 1);
  localparam int DUR_MAX  = (1 << TEMPO_W) - 1;
  localparam logic signed [TEMPO_W:0] POS_TOL = (TEMPO_W + 1)'(TOL);
  localparam logic signed [TEMPO_W:0] NEG_TOL = -POS_TOL;

  estado_t estado, prox_estado;

  logic [NOTA_W-1:0]   indice, nota_cap;
  logic                valido, multiplo, nenhum_botao, fim_espera;
  logic [ESPERA_W-1:0] espera_cnt;
  logic [TEMPO_W-1:0]  dur;
  logic                flag_timeout, flag_multi;
  logic                limpa_espera, conta_espera, captura, marca_multi;
  logic                marca_timeout, conta_dur, avalia, conta_erro;
  logic signed [TEMPO_W:0] diff;
  logic                nota_ok, tempo_ok, baixo_ok, errou_calc;

  onehot_encoder_param #(
    .N (N_NOTAS),
    .W (NOTA_W)
  ) u_encoder (
    .entrada  (botoes),
    .indice   (indice),
    .valido   (valido),
    .multiplo (multiplo)
  );

  assign nenhum_botao = (botoes == '0);
  assign fim_espera   = tick && (espera_cnt == ESPERA_W'(TIMEOUT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado <= OCIOSO;
    end else begin
      estado <= prox_estado;
    end
  end

  always_comb begin
    prox_estado = estado;
    case (estado)
      OCIOSO: if (iniciar) prox_estado = ESPERA;
      ESPERA: begin
        if (valido) begin
          prox_estado = MEDE;
        end else if (multiplo || fim_espera) begin
          prox_estado = AVALIA;
        end
      end
      MEDE:   if (nenhum_botao) prox_estado = AVALIA;
      AVALIA: prox_estado = FIM;
      FIM:    prox_estado = OCIOSO;
      default: prox_estado = OCIOSO;
    endcase
  end

  always_comb begin
    pronto        = 1'b0;
    limpa_espera  = 1'b0;
    conta_espera  = 1'b0;
    captura       = 1'b0;
    marca_multi   = 1'b0;
    marca_timeout = 1'b0;
    conta_dur     = 1'b0;
    avalia        = 1'b0;
    conta_erro    = 1'b0;
    case (estado)
      OCIOSO: limpa_espera = iniciar;
      ESPERA: begin
        conta_espera  = tick;
        captura       = valido;
        marca_multi   = multiplo;
        marca_timeout = !valido && !multiplo && fim_espera;
      end
      // The tick that coincides with the release is not part of the hold.
      MEDE:   conta_dur = tick && !nenhum_botao;
      AVALIA: avalia = 1'b1;
      FIM: begin
        pronto     = 1'b1;
        conta_erro = errou;
      end
      default: ;
    endcase
  end

  contador_m #(
    .W   (ESPERA_W),
    .MAX (TIMEOUT)
  ) u_cnt_espera (
    .clock (clock),
    .reset (reset),
    .zera  (limpa_espera),
    .conta (conta_espera),
    .valor (espera_cnt)
  );

  contador_m #(
    .W   (TEMPO_W),
    .MAX (DUR_MAX)
  ) u_cnt_dur (
    .clock (clock),
    .reset (reset),
    .zera  (limpa_espera || captura),
    .conta (conta_dur),
    .valor (dur)
  );

  contador_m #(
    .W   (ERRO_W),
    .MAX (ERRO_MAX)
  ) u_cnt_erros (
    .clock (clock),
    .reset (reset),
    .zera  (zera_erros),
    .conta (conta_erro),
    .valor (erros)
  );

  assign limite_erros = (erros == ERRO_W'(ERRO_MAX));

  // One extra bit keeps the difference from wrapping when dur < tempo_esperado.
  assign diff       = $signed({1'b0, dur}) - $signed({1'b0, tempo_esperado});
  assign nota_ok    = !flag_timeout && !flag_multi && (nota_cap == nota_esperada);
  assign tempo_ok   = !flag_timeout && (diff >= NEG_TOL) && (diff <= POS_TOL);
  assign baixo_ok   = !flag_timeout && (diff < NEG_TOL);
  assign errou_calc = flag_timeout || calcula_errou(modo, nota_ok, tempo_ok);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      nota_cap      <= '0;
      flag_timeout  <= 1'b0;
      flag_multi    <= 1'b0;
      nota_correta  <= 1'b0;
      tempo_correto <= 1'b0;
      tempo_baixo   <= 1'b0;
      errou         <= 1'b0;
      timeout       <= 1'b0;
      nota_tocada   <= '0;
      duracao       <= '0;
    end else begin
      if (limpa_espera) begin
        nota_cap      <= '0;
        flag_timeout  <= 1'b0;
        flag_multi    <= 1'b0;
        nota_correta  <= 1'b0;
        tempo_correto <= 1'b0;
        tempo_baixo   <= 1'b0;
        errou         <= 1'b0;
        timeout       <= 1'b0;
        nota_tocada   <= '0;
        duracao       <= '0;
      end
      if (captura) nota_cap <= indice;
      if (marca_multi) flag_multi <= 1'b1;
      if (marca_timeout) flag_timeout <= 1'b1;
      // Verdict is frozen here and held until the next accepted iniciar.
      if (avalia) begin
        nota_correta  <= nota_ok;
        tempo_correto <= tempo_ok;
        tempo_baixo   <= baixo_ok;
        errou         <= errou_calc;
        timeout       <= flag_timeout;
        nota_tocada   <= nota_cap;
        duracao       <= dur;
      end
    end
  end

endmodule
